// File: rtl/imem_boot_loader.sv
// Post-reset boot sequencer: copies a run-time selected program from the boot ROM into imem,
// pads imem with NOPs, zero-clears dmem, then releases the CPU from reset.
module imem_boot_loader #(
    parameter int unsigned     ILEN             = 32,
    parameter int unsigned     XLEN             = 32,
    parameter int unsigned     IMEM_DEPTH_WORDS = 256,
    parameter int unsigned     DMEM_CLEAR_WORDS = 256,
    parameter int unsigned     NUM_PROGRAMS     = 16,
    parameter logic [ILEN-1:0] NOP_WORD         = ILEN'(32'h0000_0013)
) (
    input  logic                                                          clk_i,
    input  logic                                                          rst_i,
    input  logic [$clog2(NUM_PROGRAMS)-1:0]                               prog_sel_i,
    input  logic                                                          boot_req_i,
    output logic                                                          rom_en_o,
    output logic [$clog2(NUM_PROGRAMS)+$clog2(IMEM_DEPTH_WORDS):0]        rom_addr_o,
    input  logic [ILEN-1:0]                                               rom_data_i,
    output logic                                                          imem_we_o,
    output logic [$clog2(IMEM_DEPTH_WORDS)-1:0]                           imem_waddr_o,
    output logic [ILEN-1:0]                                               imem_wdata_o,
    output logic                                                          dmem_we_o,
    output logic [((DMEM_CLEAR_WORDS > 1) ? $clog2(DMEM_CLEAR_WORDS) : 1)-1:0] dmem_waddr_o,
    output logic [XLEN-1:0]                                               dmem_wdata_o,
    output logic                                                          cpu_rst_o,
    output logic                                                          busy_o,
    output logic                                                          done_o,
    output logic                                                          err_o
);

    localparam int unsigned AW  = $clog2(IMEM_DEPTH_WORDS);
    localparam int unsigned PSW = $clog2(NUM_PROGRAMS);
    localparam int unsigned OW  = AW + 1;
    localparam int unsigned RAW = PSW + OW;
    localparam int unsigned CAW = (DMEM_CLEAR_WORDS > 1) ? $clog2(DMEM_CLEAR_WORDS) : 1;

    typedef enum logic [2:0] {
        S_HDR,
        S_HDR_WAIT,
        S_HDR_CHK,
        S_COPY,
        S_FILL,
        S_CLEAR,
        S_RUN,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [PSW-1:0]   sel_q, sel_d;
    logic [OW-1:0]    len_q, len_d;
    logic [AW-1:0]    wa_q, wa_d;
    logic [CAW-1:0]   ca_q, ca_d;
    logic             rom_en_q, rom_en_d;
    logic [RAW-1:0]   rom_addr_q, rom_addr_d;
    logic             imem_we_q, imem_we_d;
    logic [AW-1:0]    imem_waddr_q, imem_waddr_d;
    logic [ILEN-1:0]  imem_wdata_q, imem_wdata_d;
    logic             fwd_q, fwd_d;
    logic             dmem_we_q, dmem_we_d;
    logic [CAW-1:0]   dmem_waddr_q, dmem_waddr_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [OW-1:0]    wa_nxt;
    logic             launch;

    // State register and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_HDR;
            sel_q        <= '0;
            len_q        <= '0;
            wa_q         <= '0;
            ca_q         <= '0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            fwd_q        <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_waddr_q <= '0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            len_q        <= len_d;
            wa_q         <= wa_d;
            ca_q         <= ca_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            fwd_q        <= fwd_d;
            dmem_we_q    <= dmem_we_d;
            dmem_waddr_q <= dmem_waddr_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state and next-output logic; wa_q is both the imem write address and the copy read index
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        len_d        = len_q;
        wa_d         = wa_q;
        ca_d         = ca_q;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        fwd_d        = 1'b0;
        dmem_we_d    = 1'b0;
        dmem_waddr_d = dmem_waddr_q;
        cpu_rst_d    = 1'b1;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        wa_nxt       = {1'b0, wa_q} + OW'(1);
        launch       = 1'b0;

        unique case (state_q)
            S_HDR: launch = 1'b1;
            S_HDR_WAIT: state_d = S_HDR_CHK;
            S_HDR_CHK: begin
                if (rom_data_i > ILEN'(IMEM_DEPTH_WORDS)) begin
                    state_d = S_ERR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_COPY;
                    len_d   = OW'(rom_data_i);
                    wa_d    = '0;
                    if (rom_data_i != '0) begin
                        rom_en_d   = 1'b1;
                        rom_addr_d = {sel_q, OW'(1)};
                    end
                end
            end
            S_COPY, S_FILL: begin
                imem_we_d    = 1'b1;
                imem_waddr_d = wa_q;
                if ({1'b0, wa_q} < len_q) begin
                    fwd_d = 1'b1;
                end else begin
                    imem_wdata_d = NOP_WORD;
                end
                if (wa_nxt < len_q) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = {sel_q, wa_nxt + OW'(1)};
                end
                if (wa_q == AW'(IMEM_DEPTH_WORDS - 1)) begin
                    state_d = S_CLEAR;
                    ca_d    = '0;
                end else begin
                    wa_d = wa_q + AW'(1);
                    if (wa_nxt >= len_q) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_CLEAR: begin
                dmem_we_d    = 1'b1;
                dmem_waddr_d = ca_q;
                if (ca_q == CAW'(DMEM_CLEAR_WORDS - 1)) begin
                    state_d = S_RUN;
                end else begin
                    ca_d = ca_q + CAW'(1);
                end
            end
            S_RUN: begin
                if (boot_req_i) begin
                    launch = 1'b1;
                end else begin
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            S_ERR: begin
                if (boot_req_i) begin
                    launch = 1'b1;
                end else begin
                    err_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: state_d = S_HDR;
        endcase

        // Start of a boot: latch the slot and issue the header read
        if (launch) begin
            state_d    = S_HDR_WAIT;
            sel_d      = prog_sel_i;
            rom_en_d   = 1'b1;
            rom_addr_d = {prog_sel_i, OW'(0)};
            busy_d     = 1'b1;
            cpu_rst_d  = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    assign rom_en_o     = rom_en_q;
    assign rom_addr_o   = rom_addr_q;
    assign imem_we_o    = imem_we_q;
    assign imem_waddr_o = imem_waddr_q;
    // Copied words are forwarded straight from the ROM in the cycle they become valid
    assign imem_wdata_o = fwd_q ? rom_data_i : imem_wdata_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_waddr_o = dmem_waddr_q;
    assign dmem_wdata_o = XLEN'(0);
    assign cpu_rst_o    = cpu_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: per-cycle output trace compared against a timing model
// derived from the boot sequence rules, with random ROM contents and program lengths.
module tb_imem_boot_loader;

    localparam int unsigned D   = 8;
    localparam int unsigned C   = 4;
    localparam int unsigned NP  = 4;
    localparam int unsigned AW  = 3;
    localparam int unsigned PSW = 2;
    localparam int unsigned RAW = PSW + AW + 1;
    localparam int unsigned CAW = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          REL = D + C + 3;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [PSW-1:0]  prog_sel_i;
    logic            boot_req_i;
    logic            rom_en_o;
    logic [RAW-1:0]  rom_addr_o;
    logic [31:0]     rom_data_i = '0;
    logic            imem_we_o;
    logic [AW-1:0]   imem_waddr_o;
    logic [31:0]     imem_wdata_o;
    logic            dmem_we_o;
    logic [CAW-1:0]  dmem_waddr_o;
    logic [31:0]     dmem_wdata_o;
    logic            cpu_rst_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    logic [31:0] rom [0:(1<<RAW)-1];

    typedef struct packed {
        logic           rom_en;
        logic [RAW-1:0] rom_addr;
        logic           imem_we;
        logic [AW-1:0]  imem_waddr;
        logic [31:0]    imem_wdata;
        logic           dmem_we;
        logic [CAW-1:0] dmem_waddr;
        logic [31:0]    dmem_wdata;
        logic           cpu_rst;
        logic           busy;
        logic           done;
        logic           err;
    } obs_t;

    int n_vec = 0;
    int n_err = 0;

    imem_boot_loader #(
        .ILEN(32), .XLEN(32), .IMEM_DEPTH_WORDS(D), .DMEM_CLEAR_WORDS(C),
        .NUM_PROGRAMS(NP), .NOP_WORD(NOP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .prog_sel_i(prog_sel_i), .boot_req_i(boot_req_i),
        .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .imem_we_o(imem_we_o), .imem_waddr_o(imem_waddr_o), .imem_wdata_o(imem_wdata_o),
        .dmem_we_o(dmem_we_o), .dmem_waddr_o(dmem_waddr_o), .dmem_wdata_o(dmem_wdata_o),
        .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Synchronous boot ROM: data valid the cycle after the enable
    always @(posedge clk) begin
        if (rom_en_o) rom_data_i <= rom[rom_addr_o];
    end

    // Expected outputs t cycles after the start of a boot of slot sel with header len
    function automatic obs_t expect_at(input int t, input int sel, input int len);
        obs_t e;
        int   base;
        e       = '0;
        base    = sel * 2 * D;
        e.cpu_rst = 1'b1;
        e.busy    = 1'b1;
        if (t == 0) begin
            e.rom_en   = 1'b1;
            e.rom_addr = RAW'(base);
        end else if (len > D) begin
            if (t >= 2) begin
                e.busy = 1'b0;
                e.err  = 1'b1;
            end
        end else begin
            if (t >= 2 && t - 2 < len) begin
                e.rom_en   = 1'b1;
                e.rom_addr = RAW'(base + 1 + (t - 2));
            end
            if (t >= 3 && t <= D + 2) begin
                e.imem_we    = 1'b1;
                e.imem_waddr = AW'(t - 3);
                e.imem_wdata = (t - 3 < len) ? rom[base + 1 + (t - 3)] : NOP;
            end
            if (t >= D + 3 && t <= D + C + 2) begin
                e.dmem_we    = 1'b1;
                e.dmem_waddr = CAW'(t - D - 3);
            end
            if (t >= REL) begin
                e.cpu_rst = 1'b0;
                e.busy    = 1'b0;
                e.done    = 1'b1;
            end
        end
        return e;
    endfunction

    // Observed outputs; addresses and data only matter while their strobe is high
    function automatic obs_t observe(input bit raw);
        obs_t o;
        o.rom_en     = rom_en_o;
        o.rom_addr   = (raw || rom_en_o) ? rom_addr_o : '0;
        o.imem_we    = imem_we_o;
        o.imem_waddr = (raw || imem_we_o) ? imem_waddr_o : '0;
        o.imem_wdata = (raw || imem_we_o) ? imem_wdata_o : '0;
        o.dmem_we    = dmem_we_o;
        o.dmem_waddr = (raw || dmem_we_o) ? dmem_waddr_o : '0;
        o.dmem_wdata = dmem_wdata_o;
        o.cpu_rst    = cpu_rst_o;
        o.busy       = busy_o;
        o.done       = done_o;
        o.err        = err_o;
        return o;
    endfunction

    task automatic check(input string tag, input int t, input obs_t got, input obs_t exp_v);
        n_vec++;
        assert (got === exp_v) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp_v);
        end
    endtask

    task automatic check_reset(input string tag);
        obs_t r;
        r         = '0;
        r.cpu_rst = 1'b1;
        check(tag, -1, observe(1'b1), r);
    endtask

    // Caller is positioned in cycle 0 of a boot; checks cycles 0..ncyc-1
    task automatic run_seq(input string tag, input int sel, input int len, input int ncyc,
                           input int req_at);
        for (int t = 0; t < ncyc; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            check(tag, t, observe(1'b0), expect_at(t, sel, len));
            prog_sel_i = PSW'($urandom);
            boot_req_i = (t == req_at);
        end
        boot_req_i = 1'b0;
    endtask

    task automatic boot_request(input int sel);
        prog_sel_i = PSW'(sel);
        boot_req_i = 1'b1;
        @(posedge clk);
        #1;
        boot_req_i = 1'b0;
    endtask

    task automatic release_reset(input int sel);
        prog_sel_i = PSW'(sel);
        rst_i      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int len2;
        int sel;
        int len;

        for (int i = 0; i < (1 << RAW); i++) rom[i] = 32'($urandom);
        len2              = int'($urandom_range(1, D - 1));
        rom[0 * 2 * D]    = 32'd0;
        rom[1 * 2 * D]    = 32'd3;
        rom[2 * 2 * D]    = 32'(len2);
        rom[3 * 2 * D]    = 32'(D);

        rst_i      = 1'b1;
        boot_req_i = 1'b0;
        prog_sel_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");

        release_reset(1);
        run_seq("slot1_L3", 1, 3, REL + 2, -1);

        boot_request(2);
        run_seq("reboot_slot2", 2, len2, REL + 2, -1);

        boot_request(0);
        run_seq("L0", 0, 0, REL + 2, -1);

        boot_request(3);
        run_seq("L_eq_D", 3, D, REL + 2, -1);

        rom[0] = 32'd9;
        boot_request(0);
        run_seq("L9_err", 0, 9, 6, -1);
        boot_request(1);
        run_seq("err_reboot", 1, 3, REL + 2, -1);

        boot_request(1);
        run_seq("pre_abort", 1, 3, 5, -1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check_reset("abort_reset");
        release_reset(1);
        run_seq("rerun_fill_req", 1, 3, REL + 2, 7);

        for (int it = 0; it < 6; it++) begin
            sel = int'($urandom_range(0, NP - 1));
            len = int'($urandom_range(0, D + 1));
            for (int w = 1; w < 2 * D; w++) rom[sel * 2 * D + w] = 32'($urandom);
            rom[sel * 2 * D] = 32'(len);
            boot_request(sel);
            run_seq("random", sel, len, (len > D) ? 6 : REL + 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Post-reset boot sequencer that replaces compile-time program selection with run-time selection.
- Holds the CPU in reset while it does three things: copies program `prog_sel_i` from a multi-program boot ROM into instruction memory, pads the rest of imem with NOPs, and zero-clears data memory.
- Then releases the CPU. It sits at SoC top level, between the boot ROM, the imem/dmem write ports and the CPU reset.
- Supports run-time re-boot on request.

Parameters:
- ILEN, 32, instruction/ROM word width.
- XLEN, 32, dmem data width.
- IMEM_DEPTH_WORDS, 256, imem words (D); power of two, ≥2.
- DMEM_CLEAR_WORDS, 256, dmem words zeroed (C); ≥1.
- NUM_PROGRAMS, 16, ROM program slots; power of two, ≥2.
- NOP_WORD, 32'h0000_0013, pad value (addi x0,x0,0).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- prog_sel_i  in  $clog2(NUM_PROGRAMS)  program slot; sampled at sequence start only
- boot_req_i  in  1  re-boot request; honoured in RUN or ERR only
- rom_en_o  out  1  ROM read enable
- rom_addr_o  out  $clog2(NUM_PROGRAMS)+$clog2(D)+1  ROM word address
- rom_data_i  in  ILEN  ROM data; valid the cycle after rom_en_o
- imem_we_o  out  1  imem write strobe
- imem_waddr_o  out  $clog2(D)  imem word address
- imem_wdata_o  out  ILEN  imem write data
- dmem_we_o  out  1  dmem write strobe
- dmem_waddr_o  out  $clog2(DMEM_CLEAR_WORDS)  dmem word address
- dmem_wdata_o  out  XLEN  always 0
- cpu_rst_o  out  1  CPU reset, active-high
- busy_o  out  1  sequence in progress
- done_o  out  1  CPU released
- err_o  out  1  invalid program header

Behaviour:
- **Reset** (rst_i high, any state), outputs registered:
  - cpu_rst_o=1.
  - busy_o, done_o, err_o, all strobes and rom_en_o = 0.
  - All addresses and data = 0.
  - FSM → HDR.
  - Reset mid-sequence aborts immediately; a new sequence starts from scratch.
- **ROM layout:** slot stride 2·D words.
  - base = {sel, (log2D+1)'b0}.
  - Word base+0 = length L (unsigned ILEN); words base+1..base+L = program.
- **Cycle 0** (first cycle after rst_i low, or after accepted boot_req_i): state HDR.
  - Latch sel = prog_sel_i.
  - rom_en_o=1, rom_addr_o=base; busy_o=1.
- **Cycle 1**, HDR_WAIT: latch L = rom_data_i.
  - If L > D → ERR.
  - Else → COPY.
- **COPY**, pipelined 1 read/cycle:
  - Cycle 2+k (k<L): rom read of base+1+k.
  - Cycle 3+k: imem write addr k, data = ROM word.
  - COPY lasts max(L,1) cycles; the L=0 case has one idle COPY cycle.
- **FILL:** imem writes addr L..D-1 with NOP_WORD in cycles L+3..D+2.
  - Net effect: the imem write stream is exactly cycles 3..D+2, contiguous, for all 0≤L≤D.
  - The last copy write overlaps the first fill cycle only by state, never by address.
- **CLEAR:** dmem_we_o=1, addr 0..C-1, data 0, in cycles D+3..D+C+2. No overlap with imem writes.
- **RUN** from cycle D+C+3: cpu_rst_o=0, busy_o=0, done_o=1.
- **ERR:**
  - cpu_rst_o=1, err_o=1, busy_o=0.
  - No writes; imem/dmem untouched.
- **boot_req_i:**
  - In RUN or ERR: on the next cycle go to HDR. cpu_rst_o=1, done_o=0 and err_o=0 take effect that same HDR cycle.
  - In HDR..CLEAR: ignored, not queued.
- **Fixed rules:**
  - prog_sel_i changes mid-sequence have no effect.
  - Address counters never wrap: k ≤ D-1 and clear addr ≤ C-1 by construction.
  - Never two writes to one memory per cycle.
  - rom_en_o never asserted outside HDR/COPY.

Test Plan:
- D=8, C=4, slot 1 header L=3, words A,B,C:
  - imem writes cycles 3..10 = A,B,C,NOP×5.
  - dmem zero writes cycles 11..14.
  - cpu_rst_o falls cycle 15; done_o=1.
- L=0:
  - No ROM reads after cycle 0.
  - imem 0..7 = NOP in cycles 3..10; release still at cycle 15.
- L=8 (=D): 8 copied words, no NOP writes; release cycle 15.
- L=9:
  - ERR at cycle 2; err_o=1, cpu_rst_o stays 1, zero mem writes.
  - boot_req_i with prog_sel_i=1 → valid boot, err_o clears.
- RUN, then prog_sel_i=2 plus 1-cycle boot_req_i → cpu_rst_o=1 next cycle, slot 2 (base 32) loaded, release 15 cycles after restart.
- Two aborted/ignored cases:
  - rst_i pulsed during COPY → strobes 0 next cycle; full sequence reruns.
  - boot_req_i during FILL → ignored; timing unchanged.
